// File: rtl/pll_lock_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_lock_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int unsigned RELOCK_W = 8;

  // Counter width able to hold n, with one bit of headroom.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $unsigned($clog2(n)) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// N-flop synchroniser for a single asynchronous level; resets to 0.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock handshake sequencer in the reference-clock domain.
// Optional RUN-state loss-of-lock filter: PLL_LOCK_SEQ_GLITCH_FILTER_EN.
module pll_lock_sequencer
  import pll_lock_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES      = 2,
  parameter int unsigned RST_PULSE_CYCLES = 16,
  parameter int unsigned STABLE_CYCLES    = 1024,
  parameter int unsigned LOCK_TIMEOUT     = 65536,
  parameter int unsigned MAX_RETRIES      = 4,
  parameter int unsigned GLITCH_CYCLES    = 4
) (
  input  logic                refclk,
  input  logic                rst_n,
  input  logic                pll_locked,
  output logic                pll_rst,
  output logic                sys_rst_n,
  output logic                ready,
  output logic                lock_lost,
  output logic                fault,
  output logic [RELOCK_W-1:0] relock_count
);

  localparam int unsigned RW = cnt_width(RST_PULSE_CYCLES);
  localparam int unsigned TW = cnt_width(LOCK_TIMEOUT);
  localparam int unsigned SW = cnt_width(STABLE_CYCLES);
  localparam int unsigned YW = cnt_width(MAX_RETRIES);
  localparam int unsigned GW = cnt_width(GLITCH_CYCLES);

`ifdef PLL_LOCK_SEQ_GLITCH_FILTER_EN
  localparam int unsigned LOSS_CYCLES = GLITCH_CYCLES;
`else
  localparam int unsigned LOSS_CYCLES = 1;
`endif

  localparam logic [RW-1:0] RST_LAST   = RW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [YW-1:0] RETRY_LAST = YW'(MAX_RETRIES - 1);
  localparam logic [GW-1:0] LOSS_LAST  = GW'(LOSS_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock is the first qualifying cycle,
  // so STABLE itself needs STABLE_CYCLES-1 more.
  localparam logic [SW-1:0] STB_LAST   =
    SW'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 32'd0);

  state_t              state_q, state_d;
  logic [RW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [TW-1:0]       to_cnt_q, to_cnt_d;
  logic [SW-1:0]       stb_cnt_q, stb_cnt_d;
  logic [YW-1:0]       retry_q, retry_d;
  logic [GW-1:0]       loss_cnt_q, loss_cnt_d;
  logic                lock_lost_d;
  logic [RELOCK_W-1:0] relock_d;
  logic                locked_s;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (refclk),
    .rst_n(rst_n),
    .d    (pll_locked),
    .q    (locked_s)
  );

  // State and counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PLL_RST;
      rst_cnt_q  <= '0;
      to_cnt_q   <= '0;
      stb_cnt_q  <= '0;
      retry_q    <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      to_cnt_q   <= to_cnt_d;
      stb_cnt_q  <= stb_cnt_d;
      retry_q    <= retry_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    to_cnt_d    = to_cnt_q;
    stb_cnt_d   = stb_cnt_q;
    retry_d     = retry_q;
    loss_cnt_d  = loss_cnt_q;
    lock_lost_d = lock_lost;
    relock_d    = relock_count;

    case (state_q)
      PLL_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d   = WAIT_LOCK;
          rst_cnt_d = '0;
          to_cnt_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d   = STABLE;
          stb_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          retry_d   = retry_q + YW'(1);
          to_cnt_d  = '0;
          rst_cnt_d = '0;
          state_d   = (retry_q == RETRY_LAST) ? FAULT : PLL_RST;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      STABLE: begin
        // A drop takes priority over a coincident completed count.
        if (!locked_s) begin
          state_d   = WAIT_LOCK;
          stb_cnt_d = '0;
          to_cnt_d  = '0;
        end else if (stb_cnt_q == STB_LAST) begin
          state_d    = RUN;
          stb_cnt_d  = '0;
          retry_d    = '0;
          loss_cnt_d = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + SW'(1);
        end
      end
      RUN: begin
        if (!locked_s) begin
          if (loss_cnt_q == LOSS_LAST) begin
            state_d     = PLL_RST;
            rst_cnt_d   = '0;
            loss_cnt_d  = '0;
            lock_lost_d = 1'b1;
            if (relock_count != '1) begin
              relock_d = relock_count + RELOCK_W'(1);
            end
          end else begin
            loss_cnt_d = loss_cnt_q + GW'(1);
          end
        end else begin
          loss_cnt_d = '0;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = PLL_RST;
      end
    endcase
  end

  // Outputs decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst      <= 1'b1;
      sys_rst_n    <= 1'b0;
      ready        <= 1'b0;
      fault        <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= '0;
    end else begin
      pll_rst      <= (state_d == PLL_RST);
      sys_rst_n    <= (state_d == RUN);
      ready        <= (state_d == RUN);
      fault        <= (state_d == FAULT);
      lock_lost    <= lock_lost_d;
      relock_count <= relock_d;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed self-checking bench for pll_lock_sequencer (small parameter set).
module tb_pll_lock_sequencer;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int bad    = 0;

`ifdef PLL_LOCK_SEQ_GLITCH_FILTER_EN
  localparam int LOFF = 3;
`else
  localparam int LOFF = 0;
`endif

  pll_lock_sequencer #(
    .SYNC_STAGES     (2),
    .RST_PULSE_CYCLES(4),
    .STABLE_CYCLES   (8),
    .LOCK_TIMEOUT    (32),
    .MAX_RETRIES     (2),
    .GLITCH_CYCLES   (4)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .fault       (fault),
    .relock_count(relock_count)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
      cyc++;
    end
  endtask

  task automatic to_cycle(input int n);
    while (cyc < n) tick(1);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Drop lock until ready falls, then restore it until ready returns.
  task automatic lose_and_relock();
    pll_locked = 1'b0;
    for (int k = 0; k < 40 && ready !== 1'b0; k++) tick(1);
    if (ready !== 1'b0) bad++;
    pll_locked = 1'b1;
    for (int k = 0; k < 60 && ready !== 1'b1; k++) tick(1);
    if (ready !== 1'b1) bad++;
  endtask

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    tick(3);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_rst_n", sys_rst_n, 0);
    check("rst_ready", ready, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_fault", fault, 0);
    check("rst_relock", relock_count, 0);

    // Clean lock
    do_reset();
    check("clean_pll_rst_c0", pll_rst, 1);
    to_cycle(3);
    check("clean_pll_rst_c3", pll_rst, 1);
    to_cycle(4);
    check("clean_pll_rst_c4", pll_rst, 0);
    to_cycle(6);
    pll_locked = 1'b1;
    to_cycle(15);
    check("clean_sys_rst_n_c15", sys_rst_n, 0);
    to_cycle(16);
    check("clean_sys_rst_n_c16", sys_rst_n, 1);
    check("clean_ready_c16", ready, 1);
    check("clean_fault", fault, 0);
    check("clean_relock", relock_count, 0);

    // Glitch during stability window
    do_reset();
    to_cycle(6);
    pll_locked = 1'b1;
    to_cycle(10);
    pll_locked = 1'b0;
    to_cycle(11);
    pll_locked = 1'b1;
    to_cycle(16);
    check("stab_ready_c16", ready, 0);
    to_cycle(20);
    check("stab_sys_rst_n_c20", sys_rst_n, 0);
    to_cycle(21);
    check("stab_sys_rst_n_c21", sys_rst_n, 1);

    // Timeout and fault
    do_reset();
    to_cycle(4);
    check("to_pll_rst_c4", pll_rst, 0);
    to_cycle(35);
    check("to_pll_rst_c35", pll_rst, 0);
    to_cycle(36);
    check("to_pll_rst_c36", pll_rst, 1);
    to_cycle(39);
    check("to_pll_rst_c39", pll_rst, 1);
    to_cycle(40);
    check("to_pll_rst_c40", pll_rst, 0);
    to_cycle(71);
    check("to_fault_c71", fault, 0);
    to_cycle(72);
    check("to_fault_c72", fault, 1);
    check("to_pll_rst_c72", pll_rst, 0);
    check("to_sys_rst_n_c72", sys_rst_n, 0);
    to_cycle(100);
    pll_locked = 1'b1;
    to_cycle(272);
    check("to_fault_hold", fault, 1);
    check("to_pll_rst_hold", pll_rst, 0);
    check("to_sys_rst_n_hold", sys_rst_n, 0);
    check("to_ready_hold", ready, 0);

    // Loss of lock in RUN
    do_reset();
    to_cycle(6);
    pll_locked = 1'b1;
    to_cycle(20);
    check("loss_ready_c20", ready, 1);
    pll_locked = 1'b0;
    to_cycle(22 + LOFF);
    check("loss_ready_before", ready, 1);
    to_cycle(23 + LOFF);
    check("loss_sys_rst_n", sys_rst_n, 0);
    check("loss_ready", ready, 0);
    check("loss_pll_rst", pll_rst, 1);
    check("loss_lock_lost", lock_lost, 1);
    check("loss_relock", relock_count, 1);
    to_cycle(26 + LOFF);
    check("loss_pll_rst_end", pll_rst, 1);
    to_cycle(27 + LOFF);
    check("loss_pll_rst_off", pll_rst, 0);
    pll_locked = 1'b1;
    to_cycle(36 + LOFF);
    check("relock_ready_early", ready, 0);
    to_cycle(37 + LOFF);
    check("relock_ready", ready, 1);
    check("relock_lock_lost", lock_lost, 1);
    check("relock_relock", relock_count, 1);

    // Saturation of relock_count
    for (int i = 0; i < 254; i++) lose_and_relock();
    check("sat_relock_255", relock_count, 255);
    for (int i = 0; i < 5; i++) lose_and_relock();
    check("sat_relock_hold", relock_count, 255);
    check("sat_waits", bad, 0);

    // Asynchronous reset in the middle of STABLE
    pll_locked = 1'b0;
    for (int k = 0; k < 40 && ready !== 1'b0; k++) tick(1);
    pll_locked = 1'b1;
    tick(8);
    check("mid_ready_pre", ready, 0);
    check("mid_relock_pre", relock_count, 255);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_pll_rst", pll_rst, 1);
    check("mid_sys_rst_n", sys_rst_n, 0);
    check("mid_ready", ready, 0);
    check("mid_lock_lost", lock_lost, 0);
    check("mid_fault", fault, 0);
    check("mid_relock", relock_count, 0);

    // Short low pulses in RUN
    do_reset();
    to_cycle(6);
    pll_locked = 1'b1;
    to_cycle(20);
    pll_locked = 1'b0;
`ifdef PLL_LOCK_SEQ_GLITCH_FILTER_EN
    to_cycle(23);
    pll_locked = 1'b1;
    to_cycle(30);
    check("gf_ready_3low", ready, 1);
    check("gf_relock_3low", relock_count, 0);
    check("gf_lock_lost_3low", lock_lost, 0);
    pll_locked = 1'b0;
    to_cycle(34);
    pll_locked = 1'b1;
    to_cycle(35);
    check("gf_ready_4low_pre", ready, 1);
    to_cycle(36);
    check("gf_ready_4low", ready, 0);
    check("gf_relock_4low", relock_count, 1);
`else
    to_cycle(21);
    pll_locked = 1'b1;
    to_cycle(22);
    check("gl_ready_pre", ready, 1);
    to_cycle(23);
    check("gl_ready_1low", ready, 0);
    check("gl_relock_1low", relock_count, 1);
    check("gl_lock_lost_1low", lock_lost, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Consumer side of the PLL rst/locked handshake; runs in the PLL reference-clock domain.
- Drives the PLL reset pulse and synchronises the asynchronous locked output.
- Qualifies lock over a stability window, then releases the reset of the logic clocked by the PLL output clock.
- On loss of lock, holds downstream in reset, re-pulses the PLL reset, and declares a fault after repeated acquisition timeouts.

Parameters:
SYNC_STAGES, 2, flops in the pll_locked synchroniser (minimum 2)
RST_PULSE_CYCLES, 16, refclk cycles pll_rst is held high per attempt
STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required before release
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before retry
MAX_RETRIES, 4, timeouts tolerated per acquisition before FAULT
GLITCH_CYCLES, 4, loss-of-lock filter length (used only with optional feature)

Ports:
refclk  in  1  single clock; PLL reference clock
rst_n  in  1  asynchronous active-low reset
pll_locked  in  1  PLL locked output; asynchronous to refclk
pll_rst  out  1  active-high reset to PLL
sys_rst_n  out  1  active-low reset to downstream logic
ready  out  1  high while in RUN
lock_lost  out  1  sticky; set on any RUN loss of lock
fault  out  1  high in FAULT
relock_count  out  8  count of RUN->PLL_RST transitions, saturating at 255

Behaviour:
- One clock, refclk. Reset rst_n is asynchronous assert, active-low.
- Reset values: state=PLL_RST, pll_rst=1, sys_rst_n=0, ready=0, lock_lost=0, fault=0, relock_count=0, all counters 0.
- locked_s: pll_locked through SYNC_STAGES flops; the FSM sees only locked_s.
- All outputs are registered.
- States:
  - PLL_RST: pll_rst=1. After RST_PULSE_CYCLES cycles -> WAIT_LOCK, timeout counter cleared.
  - WAIT_LOCK: pll_rst=0. If locked_s=1 -> STABLE with stable counter=0.
    - If the timeout counter reaches LOCK_TIMEOUT-1 with locked_s=0: retries++.
    - If retries then equals MAX_RETRIES -> FAULT, else -> PLL_RST.
  - STABLE: counts consecutive locked_s=1 cycles.
    - Any locked_s=0 -> WAIT_LOCK; the stable counter and the timeout counter restart, and retries is unchanged.
    - On the STABLE_CYCLES-th consecutive cycle -> RUN; retries cleared.
  - RUN: sys_rst_n=1, ready=1.
    - locked_s=0 -> PLL_RST. sys_rst_n=0 and ready=0 take effect on the same registered edge as pll_rst=1.
    - lock_lost set; relock_count++ (saturating).
  - FAULT: pll_rst=0, sys_rst_n=0, fault=1. Terminal until rst_n.
- Latency: if pll_locked rises at edge t and stays high, sys_rst_n rises at edge t+SYNC_STAGES+STABLE_CYCLES (±1 for synchroniser sampling).
- Loss in RUN: sys_rst_n falls SYNC_STAGES+1 edges after pll_locked falls.
- Simultaneous events:
  - Timeout expiry and locked_s rising in the same cycle: lock wins -> STABLE.
  - Stable count complete and locked_s=0 in the same cycle: drop wins -> WAIT_LOCK.
- rst_n asserted mid-operation forces the reset values immediately. lock_lost and relock_count clear only on rst_n.
- Counter widths: $clog2 of the respective parameter + 1. No wrap is reachable.

Optional Feature:
Macro: PLL_LOCK_SEQ_GLITCH_FILTER_EN.
- Defined: in RUN, loss is declared only after GLITCH_CYCLES consecutive locked_s=0 cycles. A shorter low pulse resets the filter counter and leaves sys_rst_n and lock_lost untouched. Loss-to-sys_rst_n latency grows by GLITCH_CYCLES-1.
- Undefined: a single locked_s=0 cycle in RUN triggers re-lock. GLITCH_CYCLES is unused.

Decomposition:
- Package pll_lock_seq_pkg holds:
  - the state enum typedef (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT);
  - the 8-bit relock_count width constant;
  - a clog2-based width function.
- Sub-module sync_bit: a parameterised N-flop synchroniser with async active-low reset to 0. It is the only sub-module.

Test Plan:
Use overrides STABLE_CYCLES=8, RST_PULSE_CYCLES=4, LOCK_TIMEOUT=32, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean lock: release rst_n, raise pll_locked at cycle 6 -> pll_rst high cycles 0-3; sys_rst_n=1 and ready=1 by cycle 16; fault=0, relock_count=0.
- Stability glitch: lock at cycle 6, drop for 1 cycle at cycle 10, raise again -> stable count restarts; sys_rst_n rises 8+2 cycles after the re-rise.
- Timeout/fault: pll_locked held 0 -> two pll_rst pulses of 4 cycles each, separated by 32 WAIT_LOCK cycles; after the 2nd timeout fault=1, pll_rst=0, sys_rst_n=0, held for 200 cycles.
- Loss in RUN: in RUN, drop pll_locked -> sys_rst_n=0 within 3 edges, pll_rst 4-cycle pulse, lock_lost=1, relock_count=1. Re-raise pll_locked -> RUN again with lock_lost still 1.
- Saturation and reset: force 260 RUN losses -> relock_count=255. Assert rst_n mid-STABLE -> all outputs return to reset values asynchronously.
- Glitch filter (macro defined, GLITCH_CYCLES=4): in RUN, a 3-cycle low on locked_s -> ready stays 1; a 4-cycle low -> ready=0, relock_count increments.
